data_mem_responder: RTL and testbench

//  Responder (target) side of the single-cycle core's data-memory interface.

---
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core: a word RAM plus a
// peripheral bank with a byte output FIFO, a cycle counter and a status register.
// Loads are combinational. Stores commit on the rising clock edge.
module data_mem_responder #(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [1:0]  MemorySelector,
  output logic [31:0] ReadData,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        bus_error
);

  localparam int unsigned RamAw  = $clog2(RAM_WORDS);
  localparam int unsigned FifoAw = $clog2(FIFO_DEPTH);
  localparam logic [FifoAw:0] FullCnt = (FifoAw + 1)'(FIFO_DEPTH);

  logic [31:0]       mem [RAM_WORDS];
  logic [7:0]        fifo_mem [FIFO_DEPTH];

  logic [FifoAw-1:0] head_q, head_d, tail_q, tail_d;
  logic [FifoAw:0]   count_q, count_d;
  logic [31:0]       cycles_q, cycles_d;
  logic              ovf_q, ovf_d, bus_err_q, bus_err_d;

  logic [RamAw-1:0]  ram_idx;
  logic [1:0]        off;
  logic              sel_ram, sel_per, sel_unm;
  logic              ram_we, push_req, push_ok, pop, full, empty;
  logic              stat_wr, cyc_wr, ovf_set, bus_err_set;

  // Word-aligned addressing; the low two bits and bits above the RAM index are ignored.
  logic unused_addr;
  assign unused_addr = ^{ALUResult[31:RamAw+2], ALUResult[1:0]};

  assign ram_idx = ALUResult[RamAw+1:2];
  assign off     = ALUResult[3:2];
  assign sel_ram = (MemorySelector == 2'b00);
  assign sel_per = (MemorySelector == 2'b01);
  assign sel_unm = MemorySelector[1];

  assign full      = (count_q == FullCnt);
  assign empty     = (count_q == '0);
  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : fifo_mem[head_q];
  assign bus_error = bus_err_q;

  // Decode strobes and compute next state of the peripheral registers.
  always_comb begin
    ram_we      = MemWrite && sel_ram;
    push_req    = MemWrite && sel_per && (off == 2'd0);
    stat_wr     = MemWrite && sel_per && (off == 2'd1);
    cyc_wr      = MemWrite && sel_per && (off == 2'd2);
    bus_err_set = MemWrite && (sel_unm || (sel_per && (off == 2'd3)));
    pop         = out_valid && out_ready;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    push_ok     = push_req && (!full || pop);
    ovf_set     = push_req && full && !pop;

    head_d  = pop ? head_q + 1'b1 : head_q;
    tail_d  = push_ok ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 1'b1;
    end

    cycles_d = cyc_wr ? WriteData : cycles_q + 32'd1;

    // Sticky bits: a new event wins over a same-cycle W1C.
    ovf_d     = ovf_set || (ovf_q && !(stat_wr && WriteData[2]));
    bus_err_d = bus_err_set || (bus_err_q && !(stat_wr && WriteData[3]));
  end

  // Peripheral state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      cycles_q  <= '0;
      ovf_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      cycles_q  <= cycles_d;
      ovf_q     <= ovf_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Storage arrays are not reset; FIFO bytes are only visible while counted.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= WriteData;
    end
    if (push_ok) begin
      fifo_mem[tail_q] <= WriteData[7:0];
    end
  end

  // Combinational load mux; peripheral reads return 0 while reset is held.
  always_comb begin
    ReadData = '0;
    if (sel_ram) begin
      ReadData = mem[ram_idx];
    end else if (sel_per && reset) begin
      unique case (off)
        2'd0:    ReadData = {{(31 - FifoAw){1'b0}}, count_q};
        2'd1:    ReadData = {28'd0, bus_err_q, ovf_q, empty, full};
        2'd2:    ReadData = cycles_q;
        default: ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: expected FIFO bytes are queued
// as they are pushed and compared as the consumer drains them.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [1:0]  MemorySelector;
  logic [31:0] ReadData;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        bus_error;

  int          vectors;
  int          miscompares;
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_b;

  data_mem_responder #(
    .RAM_WORDS (256),
    .FIFO_DEPTH(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .MemWrite      (MemWrite),
    .ALUResult     (ALUResult),
    .WriteData     (WriteData),
    .MemorySelector(MemorySelector),
    .ReadData      (ReadData),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .bus_error     (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  // Drive one bus cycle at the falling edge; outputs are sampled 1 time unit later.
  task automatic bus(input logic we, input logic [1:0] sel, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic rdy);
    @(negedge clk);
    MemWrite       = we;
    MemorySelector = sel;
    ALUResult      = addr;
    WriteData      = wdata;
    out_ready      = rdy;
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    vectors++;
    if (out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_out_data got %h want 00", out_data);
    end
    vectors++;
    if (bus_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bus_error got %b want 0", bus_error);
    end
    MemorySelector = 2'b01;
    ALUResult      = 32'h4;
    #1;
    vectors++;
    if (ReadData !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_readdata got %h want 00000000", ReadData);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ram();
    bus(1'b1, 2'b00, 32'h10, 32'h12345678, 1'b0);
    bus(1'b1, 2'b00, 32'h14, 32'hA5A5_5A5A, 1'b0);
    bus(1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
    vectors++;
    if (ReadData !== 32'h12345678) begin
      miscompares++;
      $display("FAIL ram_load got %h want 12345678", ReadData);
    end
    bus(1'b0, 2'b00, 32'h410, 32'h0, 1'b0);
    vectors++;
    if (ReadData !== 32'h12345678) begin
      miscompares++;
      $display("FAIL ram_wrap got %h want 12345678", ReadData);
    end
    bus(1'b0, 2'b00, 32'h17, 32'h0, 1'b0);
    vectors++;
    if (ReadData !== 32'hA5A5_5A5A) begin
      miscompares++;
      $display("FAIL ram_unaligned got %h want a5a55a5a", ReadData);
    end
  endtask

  task automatic test_fifo_fill();
    for (int i = 1; i <= 9; i++) begin
      bus(1'b1, 2'b01, 32'h0, 32'(i), 1'b0);
      if (i <= 8) exp_q.push_back(8'(i));
      if (i > 1) begin
        vectors++;
        if (out_data !== 8'h01 || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL fill_head_stable got %h/%b want 01/1", out_data, out_valid);
        end
      end
    end
    bus(1'b0, 2'b01, 32'h4, 32'h0, 1'b0);
    vectors++;
    if (ReadData !== 32'h5) begin
      miscompares++;
      $display("FAIL fill_status got %h want 00000005", ReadData);
    end
    bus(1'b0, 2'b01, 32'h0, 32'h0, 1'b0);
    vectors++;
    if (ReadData !== 32'h8) begin
      miscompares++;
      $display("FAIL fill_count got %h want 00000008", ReadData);
    end
    for (int n = 0; n < 30 && exp_q.size() != 0; n++) begin
      bus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      exp_b = exp_q.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_b) begin
        miscompares++;
        $display("FAIL fill_drain got %h/%b want %h/1", out_data, out_valid, exp_b);
      end
    end
    bus(1'b0, 2'b01, 32'h4, 32'h0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || ReadData !== 32'h6) begin
      miscompares++;
      $display("FAIL fill_empty got status %h valid %b want 00000006 0", ReadData, out_valid);
    end
    bus(1'b1, 2'b01, 32'h4, 32'h4, 1'b0);
    bus(1'b0, 2'b01, 32'h4, 32'h0, 1'b0);
    vectors++;
    if (ReadData !== 32'h2) begin
      miscompares++;
      $display("FAIL ovf_clear got %h want 00000002", ReadData);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) begin
      bus(1'b1, 2'b01, 32'h0, 32'h11 + 32'(i), 1'b0);
      exp_q.push_back(8'h11 + 8'(i));
    end
    bus(1'b1, 2'b01, 32'h0, 32'hAA, 1'b1);
    exp_b = exp_q.pop_front();
    exp_q.push_back(8'hAA);
    vectors++;
    if (out_data !== exp_b) begin
      miscompares++;
      $display("FAIL pushpop_head got %h want %h", out_data, exp_b);
    end
    bus(1'b0, 2'b01, 32'h0, 32'h0, 1'b0);
    vectors++;
    if (ReadData !== 32'h8) begin
      miscompares++;
      $display("FAIL pushpop_count got %h want 00000008", ReadData);
    end
    bus(1'b0, 2'b01, 32'h4, 32'h0, 1'b0);
    vectors++;
    if (ReadData !== 32'h1) begin
      miscompares++;
      $display("FAIL pushpop_status got %h want 00000001", ReadData);
    end
    for (int n = 0; n < 30 && exp_q.size() != 0; n++) begin
      bus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      exp_b = exp_q.pop_front();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_b) begin
        miscompares++;
        $display("FAIL pushpop_drain got %h/%b want %h/1", out_data, out_valid, exp_b);
      end
    end
    bus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pushpop_empty got %b want 0", out_valid);
    end
  endtask

  task automatic test_cycles();
    logic [31:0] exp_c [3];
    exp_c[0] = 32'hFFFF_FFFE;
    exp_c[1] = 32'hFFFF_FFFF;
    exp_c[2] = 32'h0000_0000;
    bus(1'b1, 2'b01, 32'h8, 32'hFFFF_FFFE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus(1'b0, 2'b01, 32'h8, 32'h0, 1'b0);
      vectors++;
      if (ReadData !== exp_c[i]) begin
        miscompares++;
        $display("FAIL cycles_%0d got %h want %h", i, ReadData, exp_c[i]);
      end
    end
  endtask

  task automatic test_bus_error();
    bus(1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0);
    bus(1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
    vectors++;
    if (bus_error !== 1'b1) begin
      miscompares++;
      $display("FAIL unmapped_bus_error got %b want 1", bus_error);
    end
    vectors++;
    if (ReadData !== 32'h12345678) begin
      miscompares++;
      $display("FAIL unmapped_ram_intact got %h want 12345678", ReadData);
    end
    bus(1'b0, 2'b11, 32'h10, 32'h0, 1'b0);
    vectors++;
    if (ReadData !== 32'h0) begin
      miscompares++;
      $display("FAIL unmapped_read got %h want 00000000", ReadData);
    end
    bus(1'b1, 2'b01, 32'h4, 32'h8, 1'b0);
    bus(1'b0, 2'b01, 32'h4, 32'h0, 1'b0);
    vectors++;
    if (bus_error !== 1'b0 || ReadData !== 32'h2) begin
      miscompares++;
      $display("FAIL berr_clear got %b/%h want 0/00000002", bus_error, ReadData);
    end
    bus(1'b1, 2'b01, 32'hC, 32'h1, 1'b0);
    bus(1'b0, 2'b01, 32'hC, 32'h0, 1'b0);
    vectors++;
    if (bus_error !== 1'b1 || ReadData !== 32'h0) begin
      miscompares++;
      $display("FAIL reserved_write got %b/%h want 1/00000000", bus_error, ReadData);
    end
    bus(1'b1, 2'b01, 32'h4, 32'h8, 1'b0);
    bus(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    vectors++;
    if (bus_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reserved_clear got %b want 0", bus_error);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      bus(1'b1, 2'b01, 32'h0, 32'h31 + 32'(i), 1'b0);
      exp_q.push_back(8'h31 + 8'(i));
    end
    bus(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
      miscompares++;
      $display("FAIL middrain_head got %h/%b want %h/1", out_data, out_valid, exp_q[0]);
    end
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset_out got %h/%b want 00/0", out_data, out_valid);
    end
    @(negedge clk);
    reset          = 1'b1;
    MemorySelector = 2'b01;
    ALUResult      = 32'h8;
    #1;
    vectors++;
    if (ReadData !== 32'h0) begin
      miscompares++;
      $display("FAIL cycles_after_reset got %h want 00000000", ReadData);
    end
    bus(1'b0, 2'b01, 32'h0, 32'h0, 1'b0);
    vectors++;
    if (ReadData !== 32'h0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL count_after_reset got %h/%b want 00000000/0", ReadData, out_valid);
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b0;
    MemWrite       = 1'b0;
    ALUResult      = 32'h0;
    WriteData      = 32'h0;
    MemorySelector = 2'b00;
    out_ready      = 1'b0;
    test_reset();
    test_ram();
    test_fifo_fill();
    test_full_push_pop();
    test_cycles();
    test_bus_error();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
